complex_alu_ctrl: RTL and testbench

//  Issue stage directly upstream of the complex ALU. Accepts complex instructions over valid/ready,

---
 rtl/complex_alu_ctrl_pkg.sv | 44 ++++
 rtl/cplx_result_fifo.sv | 54 +++++
 rtl/complex_alu_ctrl.sv | 175 +++++++++++++++++
 tb/tb_complex_alu_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/complex_alu_ctrl_pkg.sv
// Shared opcodes, DSP control constants and the opcode decoder
// for the complex ALU issue stage.
package complex_alu_ctrl_pkg;

  localparam logic [2:0] OP_CMULT  = 3'b100;
  localparam logic [2:0] OP_MULADD = 3'b101;
  localparam logic [2:0] OP_MULSUB = 3'b110;

  localparam logic [3:0] ALUMODE_ADD  = 4'b0000;
  localparam logic [3:0] ALUMODE_CSUB = 4'b0011;
  localparam logic [6:0] OPMODE_M     = 7'b000_01_01;
  localparam logic [6:0] OPMODE_CM    = 7'b011_01_01;
  localparam logic [4:0] INMODE_AB    = 5'b00000;

  typedef struct packed {
    logic [15:0] alumode;
    logic [19:0] inmode;
    logic [27:0] opmode;
    logic        legal;
  } dec_t;

  // Core 1 sits in the MSBs; cores 1/3 take the accumulate path.
  function automatic dec_t decode(input logic [2:0] op);
    dec_t d;
    d.alumode = {4{ALUMODE_ADD}};
    d.inmode  = {4{INMODE_AB}};
    d.opmode  = {4{OPMODE_M}};
    d.legal   = 1'b1;
    unique case (1'b1)
      (op == OP_CMULT): ;
      (op == OP_MULADD): begin
        d.opmode = {OPMODE_CM, OPMODE_M, OPMODE_CM, OPMODE_M};
      end
      (op == OP_MULSUB): begin
        d.opmode  = {OPMODE_CM, OPMODE_M, OPMODE_CM, OPMODE_M};
        d.alumode = {ALUMODE_CSUB, ALUMODE_ADD,
                     ALUMODE_CSUB, ALUMODE_ADD};
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cplx_result_fifo.sv
// Result FIFO for the complex ALU issue stage: 32-bit entries,
// wrapping pointers, occupancy count exported for credit tracking.
module cplx_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr,
  input  logic [31:0]   i_wdata,
  input  logic          i_rd,
  output logic [31:0]   o_rdata,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_wr;
  logic          w_rd;

  assign w_rd    = i_rd && (r_cnt != '0);
  assign w_wr    = i_wr && (r_cnt != CW'(DEPTH));
  assign o_rdata = r_mem[r_rp];
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wp] <= i_wdata;
        r_wp <= (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
      end
      if (w_rd) begin
        r_rp <= (r_rp == PW'(DEPTH - 1)) ? '0 : r_rp + 1'b1;
      end
      unique case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/complex_alu_ctrl.sv
// Complex ALU issue stage: decode, ALU-latency tracking, credit FIFO.
// Optional COMPLEX_CTRL_PERF_EN adds perf_issued/perf_stall counters.
module complex_alu_ctrl #(
  parameter int ALU_LAT    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_opcode,
  input  logic [31:0] in_din_1,
  input  logic [31:0] in_din_2,
  input  logic [31:0] in_din_3,
  output logic [2:0]  alu_opcode,
  output logic [15:0] alu_alumode,
  output logic [19:0] alu_inmode,
  output logic [27:0] alu_opmode,
  output logic [3:0]  alu_cea2,
  output logic [3:0]  alu_ceb2,
  output logic [3:0]  alu_usemult,
  output logic [31:0] alu_din_1,
  output logic [31:0] alu_din_2,
  output logic [31:0] alu_din_3,
  input  logic [31:0] alu_dout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        err_illegal
`ifdef COMPLEX_CTRL_PERF_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_stall
`endif
);

  import complex_alu_ctrl_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  dec_t          w_dec;
  logic          w_acc;
  logic          w_issue;
  logic          w_illegal;
  logic          w_wr;
  logic          w_pop;
  logic          w_empty;
  logic [CW-1:0] w_cnt;
  logic [CW:0]   w_used;

  logic [CW-1:0] r_infl;
  logic          r_issue;
  logic [2:0]    r_op;
  logic          r_err;
  logic [3:0]    r_usemult;
  logic [15:0]   r_alumode;
  logic [19:0]   r_inmode;
  logic [27:0]   r_opmode;
  logic [31:0]   r_din_1;
  logic [31:0]   r_din_2;
  logic [31:0]   r_din_3;
  logic [ALU_LAT-1:0] r_vpipe;
  logic [2:0]    r_opipe [ALU_LAT];

  assign w_dec     = decode(in_opcode);
  // Credit only from registered counts: a same-cycle pop does not help.
  assign w_used    = {1'b0, r_infl} + {1'b0, w_cnt};
  assign in_ready  = rst && (w_used < (CW + 1)'(FIFO_DEPTH));
  assign w_acc     = in_valid && in_ready;
  assign w_issue   = w_acc && w_dec.legal;
  assign w_illegal = w_acc && !w_dec.legal;
  assign w_wr      = r_vpipe[ALU_LAT-1];
  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;

  assign alu_opcode  = r_opipe[ALU_LAT-1];
  assign alu_alumode = r_alumode;
  assign alu_inmode  = r_inmode;
  assign alu_opmode  = r_opmode;
  assign alu_cea2    = {4{r_issue}};
  assign alu_ceb2    = {4{r_issue}};
  assign alu_usemult = r_usemult;
  assign alu_din_1   = r_din_1;
  assign alu_din_2   = r_din_2;
  assign alu_din_3   = r_din_3;
  assign err_illegal = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_issue   <= 1'b0;
      r_op      <= '0;
      r_err     <= 1'b0;
      r_usemult <= '0;
      r_alumode <= '0;
      r_inmode  <= '0;
      r_opmode  <= '0;
      r_din_1   <= '0;
      r_din_2   <= '0;
      r_din_3   <= '0;
    end else begin
      r_issue   <= w_issue;
      r_err     <= w_illegal;
      r_usemult <= 4'hF;
      if (w_issue) begin
        r_op      <= in_opcode;
        r_alumode <= w_dec.alumode;
        r_inmode  <= w_dec.inmode;
        r_opmode  <= w_dec.opmode;
        r_din_1   <= in_din_1;
        r_din_2   <= in_din_2;
        r_din_3   <= in_din_3;
      end
    end
  end

  // Tracks the DSP pipeline so results are captured on the right cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vpipe <= '0;
      for (int i = 0; i < ALU_LAT; i++) r_opipe[i] <= '0;
    end else begin
      r_vpipe[0] <= r_issue;
      r_opipe[0] <= r_op;
      for (int i = 1; i < ALU_LAT; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
        r_opipe[i] <= r_opipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_infl <= '0;
    end else begin
      unique case ({w_issue, w_wr})
        2'b10:   r_infl <= r_infl + 1'b1;
        2'b01:   r_infl <= r_infl - 1'b1;
        default: ;
      endcase
    end
  end

  cplx_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (w_wr),
    .i_wdata (alu_dout),
    .i_rd    (w_pop),
    .o_rdata (out_data),
    .o_empty (w_empty),
    .o_count (w_cnt)
  );

`ifdef COMPLEX_CTRL_PERF_EN
  logic [31:0] r_perf_issued;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_issued <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (w_issue) r_perf_issued <= r_perf_issued + 32'd1;
      if (in_valid && !in_ready) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_issued = r_perf_issued;
  assign perf_stall  = r_perf_stall;
`endif

endmodule

// File: tb/tb_complex_alu_ctrl.sv
// Bench for complex_alu_ctrl: behavioural DSP model on the alu_* side,
// scoreboard of expected {I,Q} results against FIFO output order.
module tb_complex_alu_ctrl;

  localparam int ALU_LAT    = 4;
  localparam int FIFO_DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_opcode;
  logic [31:0] in_din_1;
  logic [31:0] in_din_2;
  logic [31:0] in_din_3;
  logic [2:0]  alu_opcode;
  logic [15:0] alu_alumode;
  logic [19:0] alu_inmode;
  logic [27:0] alu_opmode;
  logic [3:0]  alu_cea2;
  logic [3:0]  alu_ceb2;
  logic [3:0]  alu_usemult;
  logic [31:0] alu_din_1;
  logic [31:0] alu_din_2;
  logic [31:0] alu_din_3;
  logic [31:0] alu_dout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        err_illegal;
`ifdef COMPLEX_CTRL_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_stall;
`endif

  int total;
  int bad;
  int acc_n;
  int err_n;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  complex_alu_ctrl #(
    .ALU_LAT    (ALU_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_din_1    (in_din_1),
    .in_din_2    (in_din_2),
    .in_din_3    (in_din_3),
    .alu_opcode  (alu_opcode),
    .alu_alumode (alu_alumode),
    .alu_inmode  (alu_inmode),
    .alu_opmode  (alu_opmode),
    .alu_cea2    (alu_cea2),
    .alu_ceb2    (alu_ceb2),
    .alu_usemult (alu_usemult),
    .alu_din_1   (alu_din_1),
    .alu_din_2   (alu_din_2),
    .alu_din_3   (alu_din_3),
    .alu_dout    (alu_dout),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .err_illegal (err_illegal)
`ifdef COMPLEX_CTRL_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] cfn(input logic acc, input logic sub,
                                      input logic [31:0] w,
                                      input logic [31:0] x,
                                      input logic [31:0] y);
    logic signed [15:0] wi, wq, xi, xq, yi, yq, pi, pq, ri, rq;
    wi = w[31:16]; wq = w[15:0];
    xi = x[31:16]; xq = x[15:0];
    yi = y[31:16]; yq = y[15:0];
    pi = wi * xi - wq * xq;
    pq = wi * xq + wq * xi;
    ri = pi;
    rq = pq;
    if (acc) begin
      ri = sub ? yi - pi : yi + pi;
      rq = sub ? yq - pq : yq + pq;
    end
    return {ri, rq};
  endfunction

  // DSP model: result appears ALU_LAT cycles after the alu_* update.
  logic [31:0] alu_p [ALU_LAT];
  always_ff @(posedge clk) begin
    alu_p[0] <= (alu_cea2 != 4'h0)
      ? cfn(alu_opmode[27:21] == 7'b011_01_01,
            alu_alumode[15:12] == 4'b0011,
            alu_din_1, alu_din_2, alu_din_3)
      : 32'hDEAD_BEEF;
    for (int i = 1; i < ALU_LAT; i++) alu_p[i] <= alu_p[i-1];
  end
  assign alu_dout = alu_p[ALU_LAT-1];

  // One clock; records accepted legal ops and popped results.
  task automatic tick();
    logic acc;
    logic pop;
    logic [31:0] d;
    logic [31:0] e;
    acc = in_valid && in_ready &&
          (in_opcode inside {3'b100, 3'b101, 3'b110});
    e = cfn(in_opcode != 3'b100, in_opcode == 3'b110,
            in_din_1, in_din_2, in_din_3);
    pop = out_valid && out_ready;
    d = out_data;
    @(posedge clk);
    #1;
    if (acc) begin
      exp_q.push_back(e);
      acc_n++;
    end
    if (pop) got_q.push_back(d);
    if (err_illegal === 1'b1) err_n++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready);
    end
    total++;
    if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      bad++;
      $display("FAIL rst_out got=%b/%h want=0/0", out_valid, out_data);
    end
    total++;
    if ({alu_opmode, alu_alumode, alu_usemult, alu_cea2,
         alu_din_1, err_illegal} !== '0) begin
      bad++;
      $display("FAIL rst_alu got=%h/%h/%h want=0",
               alu_opmode, alu_usemult, alu_din_1);
    end
    rst = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b1 || alu_usemult !== 4'hF) begin
      bad++;
      $display("FAIL rst_release got=%b/%h want=1/f",
               in_ready, alu_usemult);
    end
  endtask

  task automatic test_op(input string nm, input logic [2:0] op,
                         input logic [27:0] x_opmode,
                         input logic [15:0] x_alumode,
                         input logic [31:0] x_data);
    logic [31:0] g, e;
    in_valid = 1'b1; in_opcode = op;
    in_din_1 = 32'h0001_0002; in_din_2 = 32'h0003_0004;
    in_din_3 = 32'h000A_0014;
    tick();
    in_valid = 1'b0;
    total++;
    if (alu_opmode !== x_opmode || alu_alumode !== x_alumode ||
        alu_inmode !== 20'h0) begin
      bad++;
      $display("FAIL %s_ctrl got=%h/%h/%h want=%h/%h/0", nm,
               alu_opmode, alu_alumode, alu_inmode, x_opmode, x_alumode);
    end
    total++;
    if (alu_cea2 !== 4'hF || alu_ceb2 !== 4'hF ||
        alu_din_1 !== 32'h0001_0002 || alu_din_2 !== 32'h0003_0004) begin
      bad++;
      $display("FAIL %s_issue got=%h/%h/%h want=f/f/00010002", nm,
               alu_cea2, alu_ceb2, alu_din_1);
    end
    tick();
    total++;
    if (alu_cea2 !== 4'h0 || alu_usemult !== 4'hF ||
        alu_opmode !== x_opmode) begin
      bad++;
      $display("FAIL %s_idle got=%h/%h/%h want=0/f/%h", nm,
               alu_cea2, alu_usemult, alu_opmode, x_opmode);
    end
    repeat (ALU_LAT - 1) tick();
    total++;
    if (out_valid !== 1'b0 || alu_opcode !== op) begin
      bad++;
      $display("FAIL %s_dout_cycle got=%b/%b want=0/%b", nm,
               out_valid, alu_opcode, op);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== x_data) begin
      bad++;
      $display("FAIL %s_latency got=%b/%h want=1/%h", nm,
               out_valid, out_data, x_data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      bad++;
      $display("FAIL %s_count got=%0d want=1", nm, got_q.size());
    end else begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      if (g !== e) begin
        bad++; $display("FAIL %s_sb got=%h want=%h", nm, g, e);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_illegal();
    int e0, ce, ov;
    e0 = err_n; ce = 0; ov = 0;
    in_valid = 1'b1; in_opcode = 3'b011;
    tick();
    in_valid = 1'b0;
    total++;
    if (err_illegal !== 1'b1) begin
      bad++; $display("FAIL ill_pulse got=%b want=1", err_illegal);
    end
    for (int i = 0; i < ALU_LAT + 4; i++) begin
      if (alu_cea2 !== 4'h0 || alu_ceb2 !== 4'h0) ce++;
      if (out_valid !== 1'b0) ov++;
      tick();
    end
    total++;
    if (err_n - e0 != 1) begin
      bad++; $display("FAIL ill_once got=%0d want=1", err_n - e0);
    end
    total++;
    if (ce != 0 || ov != 0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL ill_noissue got=%0d/%0d/%0d want=0/0/0",
               ce, ov, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int a0, sent, prev, cyc;
    logic [31:0] g, e;
    a0 = acc_n; sent = 0; cyc = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_opcode = 3'b100; in_din_3 = 32'h0;
    in_din_1 = 32'h0001_0000; in_din_2 = 32'h0003_0000;
    repeat (12) begin
      prev = acc_n;
      tick();
      if (acc_n != prev) begin
        sent++;
        in_din_1 = {16'(sent + 1), 16'(2 * sent)};
        in_din_2 = {16'(3), 16'(-sent)};
      end
    end
    total++;
    if (acc_n - a0 != FIFO_DEPTH || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_credit got=%0d/%b want=%0d/0",
               acc_n - a0, in_ready, FIFO_DEPTH);
    end
    out_ready = 1'b1;
    while ((sent < 8 || got_q.size() < 8) && cyc < 200) begin
      prev = acc_n;
      tick();
      cyc++;
      if (acc_n != prev) begin
        sent++;
        in_din_1 = {16'(sent + 1), 16'(2 * sent)};
        in_din_2 = {16'(3), 16'(-sent)};
        if (sent == 8) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    repeat (3) tick();
    out_ready = 1'b0;
    total++;
    if (cyc >= 200 || got_q.size() != 8 || exp_q.size() != 8) begin
      bad++;
      $display("FAIL b2b_count got=%0d/%0d want=8/8 cyc=%0d",
               got_q.size(), exp_q.size(), cyc);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (g !== e) begin
        bad++; $display("FAIL b2b_order got=%h want=%h", g, e);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midflight();
    int ov;
    logic [31:0] g, e;
    ov = 0;
    in_valid = 1'b1; in_opcode = 3'b100;
    in_din_1 = 32'h0002_0002; in_din_2 = 32'h0002_0002;
    repeat (3) tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_hold got=%b/%b want=0/0", in_ready, out_valid);
    end
    repeat (2) tick();
    rst = 1'b1;
    exp_q.delete(); got_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < ALU_LAT + 4; i++) begin
      if (out_valid !== 1'b0) ov++;
      tick();
    end
    total++;
    if (ov != 0 || got_q.size() != 0) begin
      bad++;
      $display("FAIL midrst_flush got=%0d/%0d want=0/0", ov, got_q.size());
    end
    in_valid = 1'b1;
    in_din_1 = 32'h0005_0001; in_din_2 = 32'h0002_0003;
    tick();
    in_valid = 1'b0;
    repeat (ALU_LAT + 5) tick();
    out_ready = 1'b0;
    total++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      bad++;
      $display("FAIL midrst_single got=%0d want=1", got_q.size());
    end else begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      if (g !== e || g !== 32'h0007_0011) begin
        bad++; $display("FAIL midrst_value got=%h want=%h", g, e);
      end
    end
`ifdef COMPLEX_CTRL_PERF_EN
    total++;
    if (perf_issued !== 32'd1) begin
      bad++; $display("FAIL perf_issued got=%0d want=1", perf_issued);
    end
`endif
  endtask

  initial begin
    total = 0; bad = 0; acc_n = 0; err_n = 0;
    rst = 1'b0; in_valid = 1'b0; in_opcode = '0;
    in_din_1 = '0; in_din_2 = '0; in_din_3 = '0; out_ready = 1'b0;
    test_reset();
    test_op("cmult", 3'b100, {4{7'b000_01_01}}, 16'h0000,
            32'hFFFB_000A);
    test_op("muladd", 3'b101,
            {7'b011_01_01, 7'b000_01_01, 7'b011_01_01, 7'b000_01_01},
            16'h0000, 32'h0005_001E);
    test_op("mulsub", 3'b110,
            {7'b011_01_01, 7'b000_01_01, 7'b011_01_01, 7'b000_01_01},
            16'h3030, 32'h000F_000A);
    test_illegal();
    test_back_to_back();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
